// File: rtl/scan_decoder_pkg.sv
// Shared constants for the scan_decoder block.
// Widths depend on module parameters, so only the mode encodings live here.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Purely combinational binary-to-one-hot decoder: out[i] = (sel == i).
module onehot_decode #(
    parameter  int SIZE_IN  = 4,
    localparam int SIZE_OUT = 2 ** SIZE_IN
) (
    input  logic [SIZE_IN-1:0]  sel,
    output logic [SIZE_OUT-1:0] out
);

    // Single active bit at the selected position.
    always_comb begin
        out      = {SIZE_OUT{1'b0}};
        out[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with direct (load) and scan (prescaled
// stepping) modes, optional active-low output polarity and a wrap pulse.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SIZE_IN    = 4,
    parameter  int DIV_WIDTH  = 16,
    parameter  bit ACTIVE_LOW = 1'b0,
    localparam int SIZE_OUT   = 2 ** SIZE_IN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 load,
    input  logic [SIZE_IN-1:0]   sel,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [SIZE_IN-1:0]   scan_last,
    output logic [SIZE_OUT-1:0]  out,
    output logic [SIZE_IN-1:0]   idx,
    output logic                 wrap
);

    localparam logic [SIZE_OUT-1:0]  POL_MASK  = {SIZE_OUT{ACTIVE_LOW}};
    localparam logic [DIV_WIDTH-1:0] TICK_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] TICK_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SIZE_IN-1:0]   IDX_ZERO  = {SIZE_IN{1'b0}};
    localparam logic [SIZE_IN-1:0]   IDX_ONE   = {{(SIZE_IN-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] tick_r;
    logic [DIV_WIDTH-1:0] tick_next_s;
    logic [SIZE_IN-1:0]   idx_r;
    logic [SIZE_IN-1:0]   idx_next_s;
    logic                 wrap_r;
    logic                 wrap_next_s;
    logic [SIZE_OUT-1:0]  out_r;
    logic [SIZE_OUT-1:0]  out_next_s;
    logic [SIZE_OUT-1:0]  onehot_s;

    // Next index/tick/wrap: en dominates, then mode, then load or prescaler tick.
    always_comb begin
        tick_next_s = tick_r;
        idx_next_s  = idx_r;
        wrap_next_s = 1'b0;
        if (!en) begin
            tick_next_s = TICK_ZERO;
        end else begin
            case (mode)
                MODE_DIRECT: begin
                    tick_next_s = TICK_ZERO;
                    if (load) begin
                        idx_next_s = sel;
                    end else begin
                        idx_next_s = idx_r;
                    end
                end
                MODE_SCAN: begin
                    // A div lowered below tick is not special-cased: tick runs on to its natural rollover.
                    if (tick_r == div) begin
                        tick_next_s = TICK_ZERO;
                        if (idx_r >= scan_last) begin
                            idx_next_s  = IDX_ZERO;
                            wrap_next_s = 1'b1;
                        end else begin
                            idx_next_s  = idx_r + IDX_ONE;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                default: begin
                    tick_next_s = TICK_ZERO;
                    idx_next_s  = idx_r;
                end
            endcase
        end
    end

    onehot_decode #(
        .SIZE_IN (SIZE_IN)
    ) u_decode (
        .sel (idx_next_s),
        .out (onehot_s)
    );

    // Polarity-adjusted output, forced inactive while disabled.
    always_comb begin
        if (en) begin
            out_next_s = onehot_s ^ POL_MASK;
        end else begin
            out_next_s = POL_MASK;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r <= TICK_ZERO;
            idx_r  <= IDX_ZERO;
            wrap_r <= 1'b0;
            out_r  <= POL_MASK;
        end else begin
            tick_r <= tick_next_s;
            idx_r  <= idx_next_s;
            wrap_r <= wrap_next_s;
            out_r  <= out_next_s;
        end
    end

    assign out  = out_r;
    assign idx  = idx_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: two instances (4-bit active-high, 3-bit
// active-low) driven by directed and random stimulus against a reference model.
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        en0 = 1'b0, mode0 = 1'b0, load0 = 1'b0;
    logic [3:0]  sel0 = 4'd0, last0 = 4'd0;
    logic [15:0] div0 = 16'd0;
    logic [15:0] out0;
    logic [3:0]  idx0;
    logic        wrap0;

    logic        en1 = 1'b0, mode1 = 1'b0, load1 = 1'b0;
    logic [2:0]  sel1 = 3'd0, last1 = 3'd0;
    logic [3:0]  div1 = 4'd0;
    logic [7:0]  out1;
    logic [2:0]  idx1;
    logic        wrap1;

    typedef struct packed {
        logic [15:0] out;
        logic [3:0]  idx;
        logic        wrap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   m_idx[2];
    int   m_tick[2];

    scan_decoder #(.SIZE_IN(4), .DIV_WIDTH(16), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .load(load0), .sel(sel0),
        .div(div0), .scan_last(last0), .out(out0), .idx(idx0), .wrap(wrap0)
    );

    scan_decoder #(.SIZE_IN(3), .DIV_WIDTH(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .load(load1), .sel(sel1),
        .div(div1), .scan_last(last1), .out(out1), .idx(idx1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what the decoder should show after the coming edge.
    function automatic exp_t model(input int d, input int size, input int dw, input bit al,
                                   input bit rn, input bit en, input bit mode, input bit load,
                                   input int sel, input int div, input int last);
        exp_t e;
        int   nout;
        e = '0;
        if (!rn) begin
            m_idx[d]  = 0;
            m_tick[d] = 0;
        end else if (!en) begin
            m_tick[d] = 0;
        end else if (!mode) begin
            m_tick[d] = 0;
            if (load) m_idx[d] = sel;
        end else if (m_tick[d] == div) begin
            m_tick[d] = 0;
            if (m_idx[d] >= last) begin
                m_idx[d] = 0;
                e.wrap   = 1'b1;
            end else begin
                m_idx[d] = m_idx[d] + 1;
            end
        end else begin
            m_tick[d] = (m_tick[d] + 1) % (1 << dw);
        end
        nout = (rn && en) ? (1 << m_idx[d]) : 0;
        if (al) nout = nout ^ ((1 << (1 << size)) - 1);
        e.out = nout[15:0];
        e.idx = m_idx[d][3:0];
        return e;
    endfunction

    // Issue the currently driven inputs for one edge and queue the expectation.
    task automatic step_cycle();
        q0.push_back(model(0, 4, 16, 1'b0, rst_n, en0, mode0, load0, int'(sel0), int'(div0), int'(last0)));
        q1.push_back(model(1, 3, 4, 1'b1, rst_n, en1, mode1, load1, int'(sel1), int'(div1), int'(last1)));
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_out0", {16'd0, out0}, 32'h0000);
        chk("rst_idx0", {28'd0, idx0}, 32'd0);
        chk("rst_wrap0", {31'd0, wrap0}, 32'd0);
        chk("rst_out1", {24'd0, out1}, 32'hFF);
        chk("rst_idx1", {29'd0, idx1}, 32'd0);
        chk("rst_wrap1", {31'd0, wrap1}, 32'd0);
        step_cycle();
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("sb_out0", {16'd0, out0}, {16'd0, e.out});
                chk("sb_idx0", {28'd0, idx0}, {28'd0, e.idx});
                chk("sb_wrap0", {31'd0, wrap0}, {31'd0, e.wrap});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sb_out1", {24'd0, out1}, {16'd0, e.out});
                chk("sb_idx1", {29'd0, idx1}, {28'd0, e.idx});
                chk("sb_wrap1", {31'd0, wrap1}, {31'd0, e.wrap});
            end
        end
    end

    initial begin
        logic [31:0] one;
        int          wraps;
        one = 32'd1;
        @(negedge clk);
        reset_now();
        step_cycle();
        rst_n = 1'b1;
        repeat (3) step_cycle();
        chk("idle_out0", {16'd0, out0}, 32'h0000);

        // Direct sweep
        en0 = 1'b1; en1 = 1'b1; load0 = 1'b1; load1 = 1'b1;
        for (int s = 0; s < 16; s++) begin
            sel0 = 4'(s);
            sel1 = 3'(s % 8);
            step_cycle();
            chk("dir_out0", {16'd0, out0}, one << s);
            chk("dir_idx0", {28'd0, idx0}, 32'(s));
        end
        load0 = 1'b0; sel0 = 4'd9;
        step_cycle();
        chk("hold_out0", {16'd0, out0}, 32'h8000);
        sel1 = 3'd5;
        step_cycle();
        chk("al_load_out1", {24'd0, out1}, 32'hDF);
        load1 = 1'b0;

        // Scan div=2 last=3 from idx 0
        load0 = 1'b1; sel0 = 4'd0;
        step_cycle();
        load0 = 1'b0; mode0 = 1'b1; div0 = 16'd2; last0 = 4'd3;
        wraps = 0;
        for (int n = 1; n <= 24; n++) begin
            step_cycle();
            chk("scan_idx0", {28'd0, idx0}, 32'((n / 3) % 4));
            chk("scan_out0", {16'd0, out0}, one << ((n / 3) % 4));
            wraps += int'(wrap0);
        end
        chk("scan_wraps", 32'(wraps), 32'd2);

        // div=0, scan_last=0
        div0 = 16'd0; last0 = 4'd0;
        for (int n = 0; n < 5; n++) begin
            step_cycle();
            chk("b0_idx0", {28'd0, idx0}, 32'd0);
            chk("b0_wrap0", {31'd0, wrap0}, 32'd1);
        end

        // Lower scan_last under the current index
        div0 = 16'd1; last0 = 4'd7;
        for (int k = 0; k < 40 && idx0 != 4'd5; k++) step_cycle();
        chk("reach5", {28'd0, idx0}, 32'd5);
        last0 = 4'd2;
        for (int k = 0; k < 5 && idx0 == 4'd5; k++) step_cycle();
        chk("lower_idx0", {28'd0, idx0}, 32'd0);
        chk("lower_wrap0", {31'd0, wrap0}, 32'd1);

        // Active-low instance: disable, then resume scanning
        en1 = 1'b0;
        step_cycle();
        chk("dis_out1", {24'd0, out1}, 32'hFF);
        chk("dis_idx1", {29'd0, idx1}, 32'd5);
        en1 = 1'b1; mode1 = 1'b1; div1 = 4'd3; last1 = 3'd7;
        for (int k = 1; k <= 4; k++) begin
            step_cycle();
            chk("resume_idx1", {29'd0, idx1}, (k < 4) ? 32'd5 : 32'd6);
        end
        chk("resume_out1", {24'd0, out1}, 32'hBF);

        // Reset mid-scan at idx=6, tick=1
        for (int k = 0; k < 64 && !(m_idx[1] == 6 && m_tick[1] == 1); k++) step_cycle();
        chk("reach6", 32'(m_idx[1] * 16 + m_tick[1]), 32'h61);
        reset_now();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step_cycle();
            chk("restart_idx1", {29'd0, idx1}, (k < 4) ? 32'd0 : 32'd1);
        end

        // Random phase
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en0 = ($urandom_range(0, 7) != 0);
            en1 = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode0 = ~mode0;
            if ($urandom_range(0, 15) == 0) mode1 = ~mode1;
            load0 = 1'($urandom);
            load1 = 1'($urandom);
            sel0 = 4'($urandom);
            sel1 = 3'($urandom);
            if ($urandom_range(0, 19) == 0) div0 = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) div1 = 4'($urandom);
            if ($urandom_range(0, 29) == 0) last0 = 4'($urandom);
            if ($urandom_range(0, 29) == 0) last1 = 3'($urandom);
            step_cycle();
        end
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("drain0", 32'(q0.size()), 32'd0);
        chk("drain1", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered binary-to-one-hot decoder for SIZE_IN select bits and 2**SIZE_IN outputs, with a selectable active-low output polarity. It has two modes. Direct mode latches an external select on a load strobe. Scan mode uses an internal prescaler to step the active output through 0..scan_last, which suits 7-segment digit and LED-matrix row scanning. It sits between board-level display controllers and the pin drivers, and replaces fixed-width combinational decoders wherever glitch-free registered selects are needed.

## Interface
- SIZE_IN, 4, select width; SIZE_OUT = 2**SIZE_IN is derived (localparam, not overridable)
- DIV_WIDTH, 16, prescaler width
- ACTIVE_LOW, 0, 1 = active output bit is 0 and inactive bits are 1
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  0 forces all outputs inactive and freezes scanning
- mode  in  1  0 = direct, 1 = scan
- load  in  1  direct mode: capture sel this cycle
- sel  in  SIZE_IN  direct-mode index
- div  in  DIV_WIDTH  scan step period minus 1, in clk cycles
- scan_last  in  SIZE_IN  highest index visited in scan mode
- out  out  SIZE_OUT  registered one-hot (or one-cold) select
- idx  out  SIZE_IN  current registered index
- wrap  out  1  one-cycle pulse when scan returns to index 0

## Operation
- Reset (rst_n low, asynchronous) sets:
  - idx = 0, tick = 0, wrap = 0
  - out = all inactive: all 0s, or all 1s when ACTIVE_LOW=1
- out is registered and always equals onehot(idx_next) gated by en, XORed with {SIZE_OUT{ACTIVE_LOW}}. idx and out update on the same edge.
- en=0 (dominates every other input):
  - out goes inactive next edge
  - idx is held, tick clears to 0, wrap = 0
  - load is ignored
- Direct mode (en=1, mode=0):
  - load=1: idx <= sel
  - load=0: idx is held
  - tick is held at 0; wrap is never asserted
- Scan mode (en=1, mode=1):
  - tick counts 0..div. When tick==div, tick <= 0 and idx steps.
  - Step: if idx >= scan_last, idx <= 0 and wrap=1 for that one cycle; otherwise idx <= idx+1.
  - load and sel are ignored.
- Boundaries:
  - div=0: idx steps every cycle.
  - scan_last=0: idx stays at 0 and wrap pulses every step.
  - scan_last=2**SIZE_IN-1: full cycle through all outputs.
  - scan_last lowered below the current idx: the next step goes to 0 with wrap.
  - div changed mid-count below the current tick: the step fires when tick wraps naturally at 2**DIV_WIDTH-1 → 0. No special handling.
- Mode switch:
  - Entering scan mode clears tick and keeps idx, so the first step occurs div+1 cycles later.
  - Entering direct mode holds idx until the next load.
- Exactly one out bit is active whenever en was 1 on the previous edge. All bits are inactive otherwise.

## Timing
- Latency:
  - load/sel sampled at edge k: out and idx reflect them after edge k (1 cycle)
  - en deassert sampled at edge k: out inactive after edge k
- Scan period per index: div+1 cycles. Full frame: (scan_last+1)*(div+1) cycles.
- wrap is high in exactly the cycle after the edge that sets idx to 0 from a scan step.
- Reset mid-operation takes effect immediately and asynchronously on out, idx, wrap and tick. The first update after release is on the first rising edge with rst_n high.
- No combinational path from any input to any output.

## Structure
- Package scan_decoder_pkg holds:
  - MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1
  - no typedefs, since widths are parameter-dependent
- Sub-module onehot_decode (parameter SIZE_IN): purely combinational binary-to-one-hot, out[i] = (sel == i). It is instantiated once on idx_next, and its output is polarity-adjusted and registered in scan_decoder.
- scan_decoder holds:
  - the tick counter
  - next-index logic as a three-way priority: en, then mode, then load/tick
  - output registers

## Test plan
- Reset with defaults (SIZE_IN=4, ACTIVE_LOW=0): rst_n low mid-cycle → out=16'h0000, idx=0, wrap=0 immediately. After release with en=0 → outputs stay inactive.
- Direct mode sweep: en=1, mode=0, load=1 with sel=0..15, one per cycle → one cycle later out = 1<<sel and idx = sel. With load=0, sel=9 → out unchanged.
- Scan mode: div=2, scan_last=3, mode=1 → idx steps 0,1,2,3,0 every 3 cycles; out=0001,0002,0004,0008 (hex); wrap pulses once per 12-cycle frame, on return to 0.
- Boundaries:
  - div=0, scan_last=0 → idx stays 0 and wrap is high every cycle.
  - Lower scan_last from 7 to 2 while idx=5 → next step gives idx=0 and wrap=1.
- ACTIVE_LOW=1, SIZE_IN=3:
  - direct load sel=5 → out=8'b1101_1111
  - en=0 → out=8'hFF next cycle and idx held at 5
  - en back to 1 in scan mode → first step after div+1 cycles
- Reset in mid-scan (idx=6, tick=1) → idx=0, tick=0 and out inactive immediately. After release, scanning restarts from 0 with the full div+1 period.
